// File: rtl/alu_result_stage.sv
// alu_result_stage: ALU result FIFO toward MEM/WB plus CCR {Z,N,V} and branch evaluation; FLAG_BYPASS_EN forwards next-CCR to br_taken
module alu_result_stage #(
    parameter int DATA_W = 16,
    parameter int REG_AW = 4,
    parameter int DEPTH  = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_result,
    input  logic              in_v,
    input  logic              in_n,
    input  logic              in_z,
    input  logic [3:0]        in_ctrl,
    input  logic [REG_AW-1:0] in_dst,
    input  logic              in_wr,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_result,
    output logic [REG_AW-1:0] out_dst,
    output logic              out_wr,
    output logic [2:0]        ccr,
    input  logic [2:0]        br_cond,
    output logic              br_taken
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [DATA_W-1:0] mem_result [DEPTH];
    logic [REG_AW-1:0] mem_dst    [DEPTH];
    logic              mem_wr     [DEPTH];
    logic [AW-1:0]     wr_ptr, rd_ptr;
    logic [CW-1:0]     count;
    logic              push, pop;
    logic [2:0]        next_ccr, flags;

    assign in_ready   = count != CW'(DEPTH);
    assign out_valid  = count != '0;
    assign push       = in_valid & in_ready & ~flush;
    assign pop        = out_valid & out_ready & ~flush;
    assign out_result = mem_result[rd_ptr];
    assign out_dst    = mem_dst[rd_ptr];
    assign out_wr     = mem_wr[rd_ptr];

    // Pointer and occupancy bookkeeping; flush empties the queue outright
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            wr_ptr <= push ? wr_ptr + AW'(1) : wr_ptr;
            rd_ptr <= pop ? rd_ptr + AW'(1) : rd_ptr;
            count  <= count + CW'(push) - CW'(pop);
        end
    end

    // Entry storage, cleared on reset so the head outputs are never X
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_result[i] <= '0;
                mem_dst[i]    <= '0;
                mem_wr[i]     <= 1'b0;
            end
        end else if (push) begin
            mem_result[wr_ptr] <= in_result;
            mem_dst[wr_ptr]    <= in_dst;
            mem_wr[wr_ptr]     <= in_wr;
        end
    end

    // Arithmetic ops (ctrl[3:2]==00) set all flags; logic/shift ops only refresh Z
    always_comb begin
        next_ccr = ccr;
        if (push)
            next_ccr = (in_ctrl[3:2] == 2'b00) ? {in_z, in_n, in_v} : {in_z, ccr[1:0]};
    end

    // Architectural condition-code register
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            ccr <= 3'b000;
        else
            ccr <= next_ccr;
    end

`ifdef FLAG_BYPASS_EN
    assign flags = next_ccr;
`else
    assign flags = ccr;
`endif

    // Branch condition decode against {Z,N,V}
    always_comb begin
        br_taken = 1'b1;
        case (br_cond)
            3'b000: br_taken = ~flags[2];
            3'b001: br_taken = flags[2];
            3'b010: br_taken = ~flags[2] & ~flags[1];
            3'b011: br_taken = flags[1];
            3'b100: br_taken = flags[2] | (~flags[2] & ~flags[1]);
            3'b101: br_taken = flags[1] | flags[2];
            3'b110: br_taken = flags[0];
            default: br_taken = 1'b1;
        endcase
    end
endmodule

// File: tb/tb_alu_result_stage.sv
// tb_alu_result_stage: directed table-driven bench for alu_result_stage
module tb_alu_result_stage;
    logic        clk = 1'b0;
    logic        rst, flush, in_valid, in_ready;
    logic [15:0] in_result, out_result;
    logic        in_v, in_n, in_z, in_wr, out_valid, out_ready, out_wr, br_taken;
    logic [3:0]  in_ctrl, in_dst, out_dst;
    logic [2:0]  ccr, br_cond;
    int errors = 0;
    int checks = 0;

    alu_result_stage dut (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
        .in_result(in_result), .in_v(in_v), .in_n(in_n), .in_z(in_z), .in_ctrl(in_ctrl),
        .in_dst(in_dst), .in_wr(in_wr), .out_valid(out_valid), .out_ready(out_ready),
        .out_result(out_result), .out_dst(out_dst), .out_wr(out_wr), .ccr(ccr),
        .br_cond(br_cond), .br_taken(br_taken)
    );

    always #10 clk = ~clk;

    typedef struct {
        logic [3:0]  ctrl;
        logic [15:0] res;
        logic        v, n, z;
        logic [2:0]  exp_ccr;
    } vec_t;

    vec_t vecs[12];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic br_model(input logic [2:0] f, input logic [2:0] c);
        logic z, n, v;
        z = f[2]; n = f[1]; v = f[0];
        case (c)
            3'd0: return !z;
            3'd1: return z;
            3'd2: return !z && !n;
            3'd3: return n;
            3'd4: return z || (!z && !n);
            3'd5: return n || z;
            3'd6: return v;
            default: return 1'b1;
        endcase
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic beat(input logic [3:0] c, input logic [15:0] r, input logic v, input logic n, input logic z, input logic [3:0] d);
        in_valid = 1'b1; in_ctrl = c; in_result = r; in_v = v; in_n = n; in_z = z; in_dst = d; in_wr = d[0];
    endtask

    task automatic do_reset();
        rst = 1'b1;
        #3;
        rst = 1'b0;
        step();
    endtask

    initial begin
        rst = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1; br_cond = 3'b000;
        in_ctrl = 4'h0; in_result = 16'h0; in_v = 0; in_n = 0; in_z = 0; in_dst = 4'h0; in_wr = 0;
        #2;
        do_reset();
        check("reset_out_valid", 32'(out_valid), 0);
        check("reset_in_ready", 32'(in_ready), 1);
        check("reset_ccr", 32'(ccr), 0);
        check("reset_out_result", 32'(out_result), 0);
        check("reset_out_dst", 32'(out_dst), 0);
        check("reset_out_wr", 32'(out_wr), 0);

        vecs[0]  = '{4'b0000, 16'h0000, 0, 0, 1, 3'b100};
        vecs[1]  = '{4'b0000, 16'h8000, 0, 1, 0, 3'b010};
        vecs[2]  = '{4'b0010, 16'h8000, 1, 1, 0, 3'b011};
        vecs[3]  = '{4'b1000, 16'h8000, 0, 1, 0, 3'b011};
        vecs[4]  = '{4'b1000, 16'h0000, 0, 0, 1, 3'b111};
        vecs[5]  = '{4'b0100, 16'h1234, 0, 0, 0, 3'b011};
        vecs[6]  = '{4'b0000, 16'h0005, 0, 0, 0, 3'b000};
        vecs[7]  = '{4'b0001, 16'h00F1, 0, 1, 0, 3'b010};
        vecs[8]  = '{4'b0011, 16'h0003, 0, 0, 0, 3'b000};
        vecs[9]  = '{4'b1100, 16'h0000, 1, 1, 1, 3'b100};
        vecs[10] = '{4'b0010, 16'hFFFF, 1, 1, 0, 3'b011};
        vecs[11] = '{4'b0000, 16'h0007, 0, 0, 0, 3'b000};
        out_ready = 1'b1;
        for (int i = 0; i < 12; i++) begin
            beat(vecs[i].ctrl, vecs[i].res, vecs[i].v, vecs[i].n, vecs[i].z, 4'(i));
            step();
            in_valid = 1'b0;
            check($sformatf("vec%0d_out_valid", i), 32'(out_valid), 1);
            check($sformatf("vec%0d_out_result", i), 32'(out_result), 32'(vecs[i].res));
            check($sformatf("vec%0d_out_dst", i), 32'(out_dst), i);
            check($sformatf("vec%0d_out_wr", i), 32'(out_wr), i % 2);
            check($sformatf("vec%0d_ccr", i), 32'(ccr), 32'(vecs[i].exp_ccr));
            for (int c = 0; c < 8; c++) begin
                br_cond = 3'(c);
                #1;
                check($sformatf("vec%0d_br%0d", i, c), 32'(br_taken), 32'(br_model(vecs[i].exp_ccr, 3'(c))));
            end
        end
        step();
        check("drain_out_valid", 32'(out_valid), 0);

        do_reset();
        out_ready = 1'b0;
        beat(4'b0000, 16'hA001, 0, 0, 0, 4'd1);
        step();
        check("bp_ready_after1", 32'(in_ready), 1);
        check("bp_head_a", 32'(out_result), 32'hA001);
        beat(4'b0000, 16'hA002, 0, 0, 0, 4'd2);
        step();
        check("bp_ready_after2", 32'(in_ready), 0);
        beat(4'b0000, 16'hA003, 0, 0, 0, 4'd3);
        step();
        check("bp_ready_full", 32'(in_ready), 0);
        check("bp_head_still_a", 32'(out_result), 32'hA001);
        out_ready = 1'b1;
        step();
        check("bp_pop_a", 32'(out_result), 32'hA002);
        check("bp_ready_reassert", 32'(in_ready), 1);
        step();
        in_valid = 1'b0;
        check("bp_pop_b", 32'(out_result), 32'hA003);
        check("bp_c_dst", 32'(out_dst), 3);
        step();
        check("bp_empty", 32'(out_valid), 0);

        do_reset();
        out_ready = 1'b0;
        beat(4'b0010, 16'h8000, 1, 1, 0, 4'd5);
        step();
        beat(4'b0000, 16'h0000, 0, 0, 1, 4'd6);
        flush = 1'b1;
        out_ready = 1'b1;
        step();
        flush = 1'b0; in_valid = 1'b0;
        check("flush_out_valid", 32'(out_valid), 0);
        check("flush_in_ready", 32'(in_ready), 1);
        check("flush_ccr_kept", 32'(ccr), 3'b011);

        do_reset();
        out_ready = 1'b0;
        beat(4'b0000, 16'h0000, 0, 0, 1, 4'd1);
        step();
        beat(4'b0000, 16'h0001, 0, 1, 0, 4'd2);
        step();
        in_valid = 1'b0;
        check("rst_pre_full", 32'(in_ready), 0);
        #4;
        rst = 1'b1;
        #1;
        check("rst_async_out_valid", 32'(out_valid), 0);
        check("rst_async_in_ready", 32'(in_ready), 1);
        check("rst_async_ccr", 32'(ccr), 0);
        rst = 1'b0;
        step();

        out_ready = 1'b1;
        br_cond = 3'b001;
        beat(4'b0000, 16'h0000, 0, 0, 1, 4'd4);
        #1;
`ifdef FLAG_BYPASS_EN
        check("bypass_same_cycle", 32'(br_taken), 1);
`else
        check("bypass_same_cycle", 32'(br_taken), 0);
`endif
        check("bypass_ccr_registered", 32'(ccr), 0);
        step();
        in_valid = 1'b0;
        #1;
        check("bypass_next_cycle", 32'(br_taken), 1);
        check("bypass_ccr_after", 32'(ccr), 3'b100);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
